// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: MEM-stage sequencer turning scalar/16-element vector
// loads and stores into one-element-per-cycle RAM accesses.
// Optional stall-cycle counter: define VMS_STALL_COUNT_EN to build it.
module vec_mem_sequencer (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_vector,
    input  logic [18:0]       base_addr,
    input  logic [4:0]        rd_in,
    input  logic [15:0][15:0] wr_data,
    output logic              req_ready,
    output logic [18:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_wren,
    input  logic [15:0]       mem_rdata,
    output logic              stall,
    output logic              done,
    output logic [4:0]        rd_out,
    output logic [15:0][15:0] rd_data,
    output logic [18:0]       stall_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic              lat_write;
    logic              lat_vector;
    logic [18:0]       lat_base;
    logic [15:0][15:0] lat_wdata;
    logic [3:0]        idx;

    logic [3:0]        last_idx;
    logic              at_last;
    logic [3:0]        idx_next;
    logic [3:0]        idx_prev;
    logic [18:0]       addr_next;

    // Element bookkeeping derived from the latched request.
    assign last_idx  = lat_vector ? 4'd15 : 4'd0;
    assign at_last   = (idx == last_idx);
    assign idx_next  = idx + 4'd1;
    assign idx_prev  = idx - 4'd1;
    assign addr_next = lat_base + {15'd0, idx_next};

    // Handshake and pipeline freeze follow the state directly.
    assign req_ready = (state == IDLE);
    assign stall     = ((state == IDLE) && req_valid)
                     || (state == ACCESS)
                     || (state == DRAIN);

    // Sequencer FSM with registered RAM-side and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            lat_write  <= 1'b0;
            lat_vector <= 1'b0;
            lat_base   <= '0;
            lat_wdata  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wren   <= 1'b0;
            done       <= 1'b0;
            rd_out     <= '0;
            rd_data    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_vector <= req_vector;
                        lat_base   <= base_addr;
                        lat_wdata  <= wr_data;
                        idx        <= 4'd0;
                        mem_addr   <= base_addr;
                        mem_wren   <= req_write;
                        mem_wdata  <= wr_data[0];
                        if (!req_write) begin
                            rd_out  <= rd_in;
                            rd_data <= '0;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read data for the previous element arrives now.
                    if (!lat_write && (idx != 4'd0)) begin
                        rd_data[idx_prev] <= mem_rdata;
                    end
                    if (at_last) begin
                        mem_wren  <= 1'b0;
                        mem_wdata <= '0;
                        if (lat_write) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx       <= idx_next;
                        mem_addr  <= addr_next;
                        mem_wdata <= lat_wdata[idx_next];
                    end
                end
                DRAIN: begin
                    rd_data[last_idx] <= mem_rdata;
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VMS_STALL_COUNT_EN
    // Saturating count of clock edges spent with the pipeline frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 19'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
